disk_resp_fifo: RTL

Response buffer directly downstream of the SD disk controller. Captures every 24-bit result word the controller emits on its `rdyi`/`outi` pair into a DEPTH-entry first-word-fall-through FIFO. Latches the controller's `inti` pulse into a sticky interrupt. Lets the CPU-side bus logic drain results at its own pace without losing words.

---
 rtl/disk_resp_fifo.sv | 118 +++++++++++
 1 files changed

// File: rtl/disk_resp_fifo.sv
// Response FIFO behind the SD disk controller: first-word-fall-through storage
// for 24-bit result words, a sticky overflow flag and a latched interrupt.
module disk_resp_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int IRQ_LEVEL = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdyi,
  input  logic [23:0]   outi,
  input  logic          inti,
  input  logic          rd,
  input  logic          clr,
  input  logic          irq_ack,
  output logic [23:0]   dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          irq
);

  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   IRQ_CNT   = (AW+1)'(IRQ_LEVEL);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          irq_pend_q, irq_pend_d;

  logic          empty_w;
  logic          full_w;
  logic          pop_ok;
  logic          push_ok;
  logic          drop;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_CNT);

  // A pop on the same edge frees a slot, so a full FIFO can still accept a push.
  assign pop_ok  = rd && !empty_w;
  assign push_ok = rdyi && (!full_w || pop_ok);
  assign drop    = rdyi && full_w && !pop_ok;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr) begin
      wp_d       = '0;
      rp_d       = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        wp_d = wp_q + PTR_ONE;
      end
      if (pop_ok) begin
        rp_d = rp_q + PTR_ONE;
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + CNT_ONE;
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - CNT_ONE;
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // A new interrupt strobe beats an acknowledge arriving in the same cycle.
  always_comb begin
    irq_pend_d = irq_pend_q;
    if (inti) begin
      irq_pend_d = 1'b1;
    end else if (irq_ack) begin
      irq_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  // Storage is left unreset; dout masking keeps stale contents invisible.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) begin
      mem_q[wp_q] <= outi;
    end
  end

  assign dout     = empty_w ? 24'h000000 : mem_q[rp_q];
  assign empty    = empty_w;
  assign full     = full_w;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign irq      = irq_pend_q || (count_q >= IRQ_CNT);

endmodule
